// File: rtl/ofmap_output_controller_pkg.sv
// Shared types for the ofmap output path: transmit FSM encoding and a
// small width helper for lane indices.
package custom_types;

  typedef enum logic [2:0] {
    OUT_IDLE    = 3'd0,
    OUT_WAIT    = 3'd1,
    OUT_READ    = 3'd2,
    OUT_CAPTURE = 3'd3,
    OUT_SEND    = 3'd4,
    OUT_DONE    = 3'd5
  } ofmap_out_state_t;

  // Index width that stays legal when a word holds a single lane.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofmap_output_controller_addr_gen.sv
// Word address counter for the read bank: holds the tile word count N and
// flags when the current address is the final word of the tile.
module output_read_addr_gen #(
  parameter int CONFIG_WIDTH    = 32,
  parameter int BANK_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       addr_enable,
  input  logic                       config_enable,
  input  logic [CONFIG_WIDTH-1:0]    config_data,
  input  logic                       clear,
  output logic [BANK_ADDR_WIDTH-1:0] addr,
  output logic                       reading_last_data
);

  logic [CONFIG_WIDTH-1:0]    n_q, n_d;
  logic [BANK_ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    n_d    = n_q;
    addr_d = addr_q;
    if (config_enable) n_d = config_data;
    if (clear) begin
      addr_d = '0;
    end else if (addr_enable) begin
      addr_d = addr_q + BANK_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q    <= '0;
      addr_q <= '0;
    end else begin
      n_q    <= n_d;
      addr_q <= addr_d;
    end
  end

  assign addr              = addr_q;
  assign reading_last_data = (CONFIG_WIDTH'(addr_q) == (n_q - CONFIG_WIDTH'(1)));

endmodule

// File: rtl/ofmap_output_controller.sv
// Drains one tile from the ofmap read bank and serializes each buffer word
// lane by lane onto a valid/ready stream, pulsing read_bank_done per tile.
module ofmap_output_controller
  import custom_types::*;
#(
  parameter int OC0             = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int CONFIG_WIDTH    = 32,
  parameter int BANK_ADDR_WIDTH = 32,
  parameter int COUNTER_WID     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       config_enable,
  input  logic [CONFIG_WIDTH-1:0]    config_data,
  input  logic                       read_bank_ready,
  output logic                       ren,
  output logic [BANK_ADDR_WIDTH-1:0] raddr,
  input  logic [OC0*DATA_WIDTH-1:0]  rdata,
  output logic [DATA_WIDTH-1:0]      output_dat,
  output logic                       output_vld,
  input  logic                       output_rdy,
  output logic                       read_bank_done,
  output logic [COUNTER_WID-1:0]     tile_count,
  output logic [2:0]                 dbg_state
);

  localparam int IDX_W = idx_width(OC0);

  ofmap_out_state_t          state_q, state_d;
  logic [OC0*DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [COUNTER_WID-1:0]    tile_q, tile_d;
  logic                      addr_inc, addr_clear, cfg_load, cfg_valid, last_word;

  assign cfg_valid = config_enable && (config_data != '0);

  output_read_addr_gen #(
    .CONFIG_WIDTH    (CONFIG_WIDTH),
    .BANK_ADDR_WIDTH (BANK_ADDR_WIDTH)
  ) u_addr_gen (
    .clk               (clk),
    .rst               (rst),
    .addr_enable       (addr_inc),
    .config_enable     (cfg_load),
    .config_data       (config_data),
    .clear             (addr_clear),
    .addr              (raddr),
    .reading_last_data (last_word)
  );

  // Stream handshake: a lane moves on a rising edge where output_vld and
  // output_rdy are both high; while vld is high and rdy low, nothing changes.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    tile_d     = tile_q;
    addr_inc   = 1'b0;
    addr_clear = 1'b0;
    cfg_load   = 1'b0;
    case (state_q)
      OUT_IDLE: begin
        if (cfg_valid) begin
          cfg_load = 1'b1;
          state_d  = OUT_WAIT;
        end
      end
      OUT_WAIT: begin
        if (cfg_valid) cfg_load = 1'b1;
        if (read_bank_ready) begin
          addr_clear = 1'b1;
          state_d    = OUT_READ;
        end
      end
      OUT_READ: state_d = OUT_CAPTURE;
      OUT_CAPTURE: begin
        word_d  = rdata;
        idx_d   = '0;
        state_d = OUT_SEND;
      end
      OUT_SEND: begin
        if (output_rdy) begin
          if (idx_q == IDX_W'(OC0 - 1)) begin
            if (last_word) begin
              state_d = OUT_DONE;
            end else begin
              addr_inc = 1'b1;
              state_d  = OUT_READ;
            end
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            word_d = word_q >> DATA_WIDTH;
          end
        end
      end
      OUT_DONE: begin
        tile_d     = tile_q + COUNTER_WID'(1);
        addr_clear = 1'b1;
        state_d    = OUT_WAIT;
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OUT_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      tile_q  <= tile_d;
    end
  end

  // Lane 0 sits in the low bits; the word shifts down as lanes are taken.
  assign ren            = (state_q == OUT_READ);
  assign output_vld     = (state_q == OUT_SEND);
  assign output_dat     = output_vld ? word_q[DATA_WIDTH-1:0] : '0;
  assign read_bank_done = (state_q == OUT_DONE);
  assign tile_count     = tile_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ofmap_output_controller.sv
// Directed bench for ofmap_output_controller: OC0=2 instance for stream,
// stall, back-to-back, reset and config cases; OC0=4 instance for N=1 timing.
module tb_ofmap_output_controller;

  localparam int OC0 = 2, DW = 16, CW = 32, AW = 32, CNT = 16;
  localparam int OC0B = 4, DWB = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              rst = 1'b1;
  logic              config_enable = 1'b0;
  logic [CW-1:0]     config_data = '0;
  logic              read_bank_ready = 1'b0;
  logic              ren;
  logic [AW-1:0]     raddr;
  logic [OC0*DW-1:0] rdata = '0;
  logic [DW-1:0]     output_dat;
  logic              output_vld, output_rdy;
  logic              read_bank_done;
  logic [CNT-1:0]    tile_count;
  logic [2:0]        dbg_state;
  logic              toggle_mode = 1'b0;

  assign output_rdy = toggle_mode ? cyc[0] : 1'b1;

  logic                config_enable_b = 1'b0;
  logic [CW-1:0]       config_data_b = '0;
  logic                ready_b = 1'b0;
  logic                ren_b;
  logic [AW-1:0]       raddr_b;
  logic [OC0B*DWB-1:0] rdata_b = '0;
  logic [DWB-1:0]      dat_b;
  logic                vld_b, done_b;
  logic                rdy_b;
  logic [CNT-1:0]      tile_count_b;
  logic [2:0]          dbg_state_b;

  assign rdy_b = 1'b1;

  ofmap_output_controller #(
    .OC0(OC0), .DATA_WIDTH(DW), .CONFIG_WIDTH(CW), .BANK_ADDR_WIDTH(AW), .COUNTER_WID(CNT)
  ) dut (
    .clk(clk), .rst(rst), .config_enable(config_enable), .config_data(config_data),
    .read_bank_ready(read_bank_ready), .ren(ren), .raddr(raddr), .rdata(rdata),
    .output_dat(output_dat), .output_vld(output_vld), .output_rdy(output_rdy),
    .read_bank_done(read_bank_done), .tile_count(tile_count), .dbg_state(dbg_state)
  );

  ofmap_output_controller #(
    .OC0(OC0B), .DATA_WIDTH(DWB), .CONFIG_WIDTH(CW), .BANK_ADDR_WIDTH(AW), .COUNTER_WID(CNT)
  ) dut_b (
    .clk(clk), .rst(rst), .config_enable(config_enable_b), .config_data(config_data_b),
    .read_bank_ready(ready_b), .ren(ren_b), .raddr(raddr_b), .rdata(rdata_b),
    .output_dat(dat_b), .output_vld(vld_b), .output_rdy(rdy_b),
    .read_bank_done(done_b), .tile_count(tile_count_b), .dbg_state(dbg_state_b)
  );

  // buffer models: word k of the A bank holds lanes {2k+2, 2k+1}
  always @(posedge clk) begin
    if (ren) rdata <= {16'(2 * raddr + 2), 16'(2 * raddr + 1)};
    if (ren_b) rdata_b <= {8'(4 * raddr_b + 4), 8'(4 * raddr_b + 3),
                           8'(4 * raddr_b + 2), 8'(4 * raddr_b + 1)};
  end

  // scoreboard
  logic [DW-1:0]  exp_q[$];
  logic [AW-1:0]  exp_addr_q[$];
  logic [DWB-1:0] got_b[$];
  int total = 0, bad = 0;
  int ren_cnt = 0, done_cnt = 0, xfer_cnt = 0, stall_cnt = 0, renb_cnt = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_stall) begin
      chk("stall_vld", output_vld, 1);
      chk("stall_dat", output_dat, prev_dat);
    end
    if (output_vld && output_rdy) begin
      xfer_cnt++;
      if (exp_q.size() == 0) chk("lane_unexpected", exp_q.size(), 1);
      else chk("lane", output_dat, exp_q.pop_front());
    end
    if (ren) begin
      ren_cnt++;
      if (exp_addr_q.size() == 0) chk("raddr_unexpected", exp_addr_q.size(), 1);
      else chk("raddr", raddr, exp_addr_q.pop_front());
    end
    if (read_bank_done) done_cnt++;
    if (output_vld && !output_rdy) stall_cnt++;
    prev_stall = output_vld && !output_rdy && !rst;
    prev_dat   = output_dat;
  end

  always @(negedge clk) begin
    if (vld_b && rdy_b) got_b.push_back(dat_b);
    if (ren_b) renb_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [CW-1:0] n);
    config_enable = 1'b1;
    config_data   = n;
    tick();
    config_enable = 1'b0;
    config_data   = '0;
  endtask

  task automatic push_tile(input int n);
    for (int k = 0; k < n; k++) begin
      exp_addr_q.push_back(AW'(k));
      exp_q.push_back(16'(2 * k + 1));
      exp_q.push_back(16'(2 * k + 2));
    end
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (read_bank_done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) chk("done_timeout", read_bank_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, d1, d2, rc, r0, x0, dn0, s0;
    logic found;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_vld", output_vld, 0);
    chk("rst_ren", ren, 0);
    chk("rst_dat", output_dat, 0);
    chk("rst_done", read_bank_done, 0);
    chk("rst_tiles", tile_count, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_state", dbg_state, 0);
    tick();
    rst = 1'b0;

    // tile 1: N=4, rdy high
    r0 = ren_cnt; x0 = xfer_cnt; dn0 = done_cnt;
    push_tile(4);
    configure(4);
    read_bank_ready = 1'b1;
    @(negedge clk);
    start = cyc;
    chk("wait_state", dbg_state, 1);
    tick();
    read_bank_ready = 1'b0;
    wait_done(60, d1);
    chk("t1_latency", d1 - start, 17);
    @(negedge clk);
    chk("t1_done_width", read_bank_done, 0);
    chk("t1_back_wait", dbg_state, 1);
    chk("t1_reads", ren_cnt - r0, 4);
    chk("t1_xfers", xfer_cnt - x0, 8);
    chk("t1_done_cnt", done_cnt - dn0, 1);
    chk("t1_exp_left", exp_q.size(), 0);
    chk("t1_tiles", tile_count, 1);

    // tile 2: rdy toggling every cycle
    tick();
    toggle_mode = 1'b1;
    x0 = xfer_cnt; s0 = stall_cnt;
    push_tile(4);
    read_bank_ready = 1'b1;
    tick();
    read_bank_ready = 1'b0;
    wait_done(200, d1);
    @(negedge clk);
    chk("t2_xfers", xfer_cnt - x0, 8);
    chk("t2_stalled", (stall_cnt - s0) > 0, 1);
    chk("t2_exp_left", exp_q.size(), 0);
    chk("t2_tiles", tile_count, 2);
    tick();
    toggle_mode = 1'b0;

    // tiles 3 and 4 back to back with ready held
    push_tile(4);
    push_tile(4);
    read_bank_ready = 1'b1;
    @(negedge clk);
    start = cyc;
    wait_done(60, d1);
    chk("t3_latency", d1 - start, 17);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ren) found = 1'b1;
    end
    rc = cyc;
    chk("t4_restart_seen", found, 1);
    chk("t4_restart_gap", rc - d1, 2);
    chk("t4_restart_raddr", raddr, 0);
    read_bank_ready = 1'b0;
    wait_done(60, d2);
    chk("t4_latency", d2 - d1 - 1, 17);
    r0 = ren_cnt;
    repeat (5) @(negedge clk);
    chk("t4_tiles", tile_count, 4);
    chk("t4_no_third", ren_cnt - r0, 0);
    chk("t4_exp_left", exp_q.size(), 0);

    // reset during SEND of word 2
    tick();
    push_tile(4);
    read_bank_ready = 1'b1;
    tick();
    read_bank_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (output_vld && raddr == 2) found = 1'b1;
    end
    chk("reach_word2", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_vld", output_vld, 0);
    chk("arst_dat", output_dat, 0);
    chk("arst_raddr", raddr, 0);
    chk("arst_tiles", tile_count, 0);
    chk("arst_state", dbg_state, 0);
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    r0 = ren_cnt;
    read_bank_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("post_rst_idle", dbg_state, 0);
    chk("post_rst_no_ren", ren_cnt - r0, 0);
    tick();
    x0 = xfer_cnt;
    push_tile(1);
    configure(1);
    @(negedge clk);
    start = cyc;
    tick();
    read_bank_ready = 1'b0;
    wait_done(30, d1);
    chk("n1_latency", d1 - start, 5);
    @(negedge clk);
    chk("n1_xfers", xfer_cnt - x0, 2);
    chk("n1_tiles", tile_count, 1);

    // config_data=0 ignored in IDLE; config during SEND ignored
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0 = ren_cnt;
    config_enable = 1'b1;
    config_data = '0;
    read_bank_ready = 1'b1;
    tick();
    config_enable = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("cfg0_idle", dbg_state, 0);
    chk("cfg0_no_ren", ren_cnt - r0, 0);
    tick();
    x0 = xfer_cnt;
    push_tile(4);
    configure(4);
    @(negedge clk);
    start = cyc;
    tick();
    read_bank_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (output_vld) found = 1'b1;
    end
    chk("cfg9_in_send", found, 1);
    config_enable = 1'b1;
    config_data = 9;
    tick();
    config_enable = 1'b0;
    config_data = '0;
    wait_done(80, d1);
    chk("cfg9_latency", d1 - start, 17);
    @(negedge clk);
    chk("cfg9_xfers", xfer_cnt - x0, 8);
    chk("cfg9_exp_left", exp_q.size(), 0);

    // reload N=1 while in WAIT
    tick();
    x0 = xfer_cnt;
    configure(1);
    push_tile(1);
    read_bank_ready = 1'b1;
    @(negedge clk);
    start = cyc;
    tick();
    read_bank_ready = 1'b0;
    wait_done(30, d1);
    chk("reload_latency", d1 - start, 5);
    @(negedge clk);
    chk("reload_xfers", xfer_cnt - x0, 2);
    chk("reload_tiles", tile_count, 2);

    // OC0=4 instance, N=1
    tick();
    config_enable_b = 1'b1;
    config_data_b = 1;
    tick();
    config_enable_b = 1'b0;
    config_data_b = '0;
    ready_b = 1'b1;
    @(negedge clk);
    start = cyc;
    tick();
    ready_b = 1'b0;
    d1 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_b) begin
        d1 = cyc;
        break;
      end
    end
    chk("b_done_seen", done_b, 1);
    chk("b_latency", d1 - start, 7);
    repeat (3) @(negedge clk);
    chk("b_reads", renb_cnt, 1);
    chk("b_xfers", got_b.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [DWB-1:0] v;
      v = (i < got_b.size()) ? got_b[i] : '0;
      chk("b_lane", v, 8'(i + 1));
    end
    chk("b_tiles", tile_count_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
